// File: rtl/rocketcpu_bus_scheduler.sv
// Round-robin Wishbone arbiter for ibus/dbus/dma sharing one slave port.
// A granted transfer that waits TIMEOUT cycles for an ack is terminated with a zero-data ack.
//
// state  | meaning
// S_IDLE | no transfer in flight; arbitrate among asserted i_*_cyc
// S_BUSY | grant held until slave ack, master abort or timeout

module rocketcpu_bus_scheduler #(
   parameter int TIMEOUT = 255
) (
   input  logic        i_wb_clk,
   input  logic        reset,

   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,

   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,

   input  logic [31:0] i_dma_adr,
   input  logic [31:0] i_dma_dat,
   input  logic [3:0]  i_dma_sel,
   input  logic        i_dma_we,
   input  logic        i_dma_cyc,
   output logic [31:0] o_dma_rdt,
   output logic        o_dma_ack,

   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,

   output logic        o_timeout_err,
   input  logic        i_err_clr,
   output logic [1:0]  o_grant
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant, grant_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    req;
   logic [1:0]    pick;
   logic          pick_vld;
   logic          busy;
   logic          g_cyc;
   logic          xfer_ack, xfer_abort, xfer_tmo, xfer_end;
   logic          ack_live;

   assign req  = {i_dma_cyc, i_dbus_cyc, i_ibus_cyc};
   assign busy = (state == S_BUSY);

   // ptr holds the master index (0 ibus, 1 dbus, 2 dma) with highest priority
   always_comb begin
      pick     = 2'd0;
      pick_vld = |req;
      case (ptr)
         2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      case (grant)
         2'd1:    g_cyc = i_ibus_cyc;
         2'd2:    g_cyc = i_dbus_cyc;
         2'd3:    g_cyc = i_dma_cyc;
         default: g_cyc = 1'b0;
      endcase
   end

   // A slave ack always wins over abort and timeout in the same cycle
   assign xfer_ack   = busy & i_wb_ack;
   assign xfer_abort = busy & ~i_wb_ack & ~g_cyc;
   assign xfer_tmo   = busy & ~i_wb_ack & g_cyc & (cnt == CW'(TIMEOUT));
   assign xfer_end   = xfer_ack | xfer_abort | xfer_tmo;

   always_ff @(posedge i_wb_clk) begin
      if (reset) begin
         state <= S_IDLE;
         grant <= 2'd0;
         ptr   <= 2'd0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               state_nxt = S_BUSY;
               grant_nxt = pick + 2'd1;
            end
         end
         S_BUSY: begin
            if (xfer_end) begin
               state_nxt = S_IDLE;
               grant_nxt = 2'd0;
               ptr_nxt   = (grant == 2'd3) ? 2'd0 : grant;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Counter idles at zero, so it is already clear on the first BUSY cycle
   always_ff @(posedge i_wb_clk) begin
      if (reset)
         cnt <= '0;
      else if (!busy)
         cnt <= '0;
      else if (!i_wb_ack)
         cnt <= cnt + CW'(1);
   end

   always_ff @(posedge i_wb_clk) begin
      if (reset)
         o_timeout_err <= 1'b0;
      else if (xfer_tmo)
         o_timeout_err <= 1'b1;
      else if (i_err_clr)
         o_timeout_err <= 1'b0;
   end

   assign ack_live = busy & ~reset & (i_wb_ack | xfer_tmo);

   always_comb begin
      o_wb_adr = 32'h0;
      o_wb_dat = 32'h0;
      o_wb_sel = 4'h0;
      o_wb_we  = 1'b0;
      case (grant)
         2'd1: begin
            o_wb_adr = i_ibus_adr;
            o_wb_sel = 4'hF;
         end
         2'd2: begin
            o_wb_adr = i_dbus_adr;
            o_wb_dat = i_dbus_dat;
            o_wb_sel = i_dbus_sel;
            o_wb_we  = i_dbus_we;
         end
         2'd3: begin
            o_wb_adr = i_dma_adr;
            o_wb_dat = i_dma_dat;
            o_wb_sel = i_dma_sel;
            o_wb_we  = i_dma_we;
         end
         default: ;
      endcase
      o_wb_cyc   = busy & g_cyc & ~reset;
      o_ibus_ack = ack_live & (grant == 2'd1);
      o_dbus_ack = ack_live & (grant == 2'd2);
      o_dma_ack  = ack_live & (grant == 2'd3);
      o_ibus_rdt = (xfer_tmo && grant == 2'd1) ? 32'h0 : i_wb_rdt;
      o_dbus_rdt = (xfer_tmo && grant == 2'd2) ? 32'h0 : i_wb_rdt;
      o_dma_rdt  = (xfer_tmo && grant == 2'd3) ? 32'h0 : i_wb_rdt;
   end

   assign o_grant = grant;

endmodule

// File: tb/tb_rocketcpu_bus_scheduler.sv
// Bench for rocketcpu_bus_scheduler: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model.

module tb_rocketcpu_bus_scheduler;

   localparam int TIMEOUT = 4;

   logic i_wb_clk = 1'b0;
   always #5 i_wb_clk = ~i_wb_clk;

   logic        reset;
   logic [31:0] m_adr [3];
   logic [31:0] m_dat [3];
   logic [3:0]  m_sel [3];
   logic        m_we  [3];
   logic        m_cyc [3];
   logic [31:0] i_wb_rdt;
   logic        i_wb_ack;
   logic        i_err_clr;

   logic [31:0] o_ibus_rdt, o_dbus_rdt, o_dma_rdt;
   logic        o_ibus_ack, o_dbus_ack, o_dma_ack;
   logic [31:0] o_wb_adr, o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we, o_wb_cyc;
   logic        o_timeout_err;
   logic [1:0]  o_grant;
   logic [2:0]  acks;

   int n_cmp  = 0;
   int n_fail = 0;

   assign acks = {o_dma_ack, o_dbus_ack, o_ibus_ack};

   rocketcpu_bus_scheduler #(.TIMEOUT(TIMEOUT)) dut (
      .i_wb_clk      (i_wb_clk),
      .reset         (reset),
      .i_ibus_adr    (m_adr[0]),
      .i_ibus_cyc    (m_cyc[0]),
      .o_ibus_rdt    (o_ibus_rdt),
      .o_ibus_ack    (o_ibus_ack),
      .i_dbus_adr    (m_adr[1]),
      .i_dbus_dat    (m_dat[1]),
      .i_dbus_sel    (m_sel[1]),
      .i_dbus_we     (m_we[1]),
      .i_dbus_cyc    (m_cyc[1]),
      .o_dbus_rdt    (o_dbus_rdt),
      .o_dbus_ack    (o_dbus_ack),
      .i_dma_adr     (m_adr[2]),
      .i_dma_dat     (m_dat[2]),
      .i_dma_sel     (m_sel[2]),
      .i_dma_we      (m_we[2]),
      .i_dma_cyc     (m_cyc[2]),
      .o_dma_rdt     (o_dma_rdt),
      .o_dma_ack     (o_dma_ack),
      .o_wb_adr      (o_wb_adr),
      .o_wb_dat      (o_wb_dat),
      .o_wb_sel      (o_wb_sel),
      .o_wb_we       (o_wb_we),
      .o_wb_cyc      (o_wb_cyc),
      .i_wb_rdt      (i_wb_rdt),
      .i_wb_ack      (i_wb_ack),
      .o_timeout_err (o_timeout_err),
      .i_err_clr     (i_err_clr),
      .o_grant       (o_grant)
   );

   function automatic logic [31:0] rdt_of(input int m);
      case (m)
         0:       return o_ibus_rdt;
         1:       return o_dbus_rdt;
         default: return o_dma_rdt;
      endcase
   endfunction

   task automatic idle_all();
      for (int m = 0; m < 3; m++) begin
         m_adr[m] = 32'h0;
         m_dat[m] = 32'h0;
         m_sel[m] = 4'h0;
         m_we[m]  = 1'b0;
         m_cyc[m] = 1'b0;
      end
      i_wb_ack  = 1'b0;
      i_wb_rdt  = 32'h0;
      i_err_clr = 1'b0;
   endtask

   task automatic set_req(input int m, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we);
      m_adr[m] = adr;
      m_dat[m] = dat;
      m_sel[m] = sel;
      m_we[m]  = we;
      m_cyc[m] = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge i_wb_clk);
      reset = 1'b1;
      idle_all();
      @(negedge i_wb_clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge i_wb_clk);
      reset = 1'b1;
      idle_all();
      m_cyc[0] = 1'b1;
      m_cyc[1] = 1'b1;
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", o_grant); end
      n_cmp++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_wb_cyc: got %b want 0", o_wb_cyc); end
      n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", acks); end
      n_cmp++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_timeout_err); end
      reset = 1'b0;
      idle_all();
      i_wb_ack = 1'b1;
      i_wb_rdt = 32'h1111_2222;
      #1;
      n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 000", acks); end
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      #1;
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL idle_no_req_grant: got %0d want 0", o_grant); end
      n_cmp++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_cyc: got %b want 0", o_wb_cyc); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      set_req(0, 32'h0000_1000, 32'h0, 4'h0, 1'b0);
      set_req(1, 32'h0000_2000, 32'h0000_CAFE, 4'h3, 1'b1);
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL sim_first_grant: got %0d want 1", o_grant); end
      n_cmp++; if (o_wb_adr !== 32'h0000_1000) begin n_fail++; $display("FAIL sim_ibus_adr: got %h want 00001000", o_wb_adr); end
      n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL sim_no_early_ack: got %b want 000", acks); end
      @(negedge i_wb_clk);
      i_wb_ack = 1'b1;
      i_wb_rdt = 32'h0BAD_F00D;
      #1;
      n_cmp++; if (acks !== 3'b001) begin n_fail++; $display("FAIL sim_ibus_ack: got %b want 001", acks); end
      n_cmp++; if (o_ibus_rdt !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL sim_ibus_rdt: got %h want 0badf00d", o_ibus_rdt); end
      n_cmp++; if (o_dbus_rdt !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL sim_dbus_rdt_bcast: got %h want 0badf00d", o_dbus_rdt); end
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[0] = 1'b0;
      #1;
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL sim_idle_gap: got %0d want 0", o_grant); end
      n_cmp++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL sim_idle_cyc: got %b want 0", o_wb_cyc); end
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd2) begin n_fail++; $display("FAIL sim_second_grant: got %0d want 2", o_grant); end
      n_cmp++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== {32'h0000_2000, 32'h0000_CAFE, 4'h3, 1'b1}) begin
         n_fail++; $display("FAIL sim_dbus_fields: got %h/%h/%h/%b want 00002000/0000cafe/3/1", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
      end
      i_wb_ack = 1'b1;
      #1;
      n_cmp++; if (acks !== 3'b010) begin n_fail++; $display("FAIL sim_dbus_ack: got %b want 010", acks); end
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[1] = 1'b0;
   endtask

   task automatic test_round_robin();
      int cnt_ack [3];
      do_reset();
      for (int m = 0; m < 3; m++) begin
         cnt_ack[m] = 0;
         set_req(m, 32'h1000_0000 + 32'(m * 16), 32'h0, 4'hF, 1'b0);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge i_wb_clk);
         i_wb_ack = 1'b1;
         i_wb_rdt = 32'hA000_0000 + 32'(k);
         #1;
         n_cmp++; if (o_grant !== 2'(k % 3 + 1)) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d want %0d", k, o_grant, k % 3 + 1); end
         n_cmp++; if (acks !== (3'b001 << (k % 3))) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", k, acks, 3'b001 << (k % 3)); end
         for (int m = 0; m < 3; m++) if (acks[m]) cnt_ack[m]++;
         @(negedge i_wb_clk);
         i_wb_ack = 1'b0;
         #1;
         n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL rr_gap_%0d: got %0d want 0", k, o_grant); end
      end
      for (int m = 0; m < 3; m++) begin
         n_cmp++; if (cnt_ack[m] != 2) begin n_fail++; $display("FAIL rr_ack_count_m%0d: got %0d want 2", m, cnt_ack[m]); end
      end
      idle_all();
   endtask

   task automatic test_write();
      set_req(0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL wr_pre_grant: got %0d want 1", o_grant); end
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[0] = 1'b0;
      set_req(1, 32'h0200_0000, 32'h0000_0001, 4'hF, 1'b1);
      set_req(0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd2) begin n_fail++; $display("FAIL wr_grant: got %0d want 2", o_grant); end
      n_cmp++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc} !== {32'h0200_0000, 32'h1, 4'hF, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL wr_fields: got %h/%h/%h/%b/%b want 02000000/00000001/f/1/1", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc);
      end
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[1] = 1'b0;
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL wr_ibus_grant: got %0d want 1", o_grant); end
      n_cmp++; if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== {32'h0000_0200, 32'h0, 4'hF, 1'b0}) begin
         n_fail++; $display("FAIL wr_ibus_fields: got %h/%h/%h/%b want 00000200/00000000/f/0", o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
      end
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[0] = 1'b0;
   endtask

   task automatic test_timeout();
      set_req(2, 32'h3000_0000, 32'h0000_0055, 4'h3, 1'b0);
      i_wb_rdt = 32'hDEAD_BEEF;
      for (int k = 0; k <= TIMEOUT; k++) begin
         @(negedge i_wb_clk);
         i_err_clr = (k == TIMEOUT);
         #1;
         if (k == 0) begin
            n_cmp++; if (o_grant !== 2'd3) begin n_fail++; $display("FAIL to_grant: got %0d want 3", o_grant); end
         end
         if (k < TIMEOUT) begin
            n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL to_wait_%0d: got %b want 000", k, acks); end
         end else begin
            n_cmp++; if (acks !== 3'b100) begin n_fail++; $display("FAIL to_forced_ack: got %b want 100", acks); end
            n_cmp++; if (o_dma_rdt !== 32'h0) begin n_fail++; $display("FAIL to_rdt_zero: got %h want 0", o_dma_rdt); end
            n_cmp++; if (o_ibus_rdt !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_other_rdt: got %h want deadbeef", o_ibus_rdt); end
            n_cmp++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b want 0", o_timeout_err); end
         end
      end
      @(negedge i_wb_clk);
      i_err_clr = 1'b0;
      m_cyc[2]  = 1'b0;
      #1;
      n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL to_single_pulse: got %b want 000", acks); end
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL to_back_idle: got %0d want 0", o_grant); end
      n_cmp++; if (o_timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set_wins: got %b want 1", o_timeout_err); end
      repeat (3) @(negedge i_wb_clk);
      n_cmp++; if (o_timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", o_timeout_err); end
      i_err_clr = 1'b1;
      @(negedge i_wb_clk);
      i_err_clr = 1'b0;
      n_cmp++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_clr: got %b want 0", o_timeout_err); end
   endtask

   task automatic test_ack_at_timeout();
      set_req(2, 32'h3000_0004, 32'h0, 4'hF, 1'b0);
      for (int k = 0; k <= TIMEOUT; k++) begin
         @(negedge i_wb_clk);
         i_wb_ack = (k == TIMEOUT);
         i_wb_rdt = 32'h1234_5678;
         #1;
         if (k < TIMEOUT) begin
            n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL at_wait_%0d: got %b want 000", k, acks); end
         end else begin
            n_cmp++; if (acks !== 3'b100) begin n_fail++; $display("FAIL at_ack: got %b want 100", acks); end
            n_cmp++; if (o_dma_rdt !== 32'h1234_5678) begin n_fail++; $display("FAIL at_rdt: got %h want 12345678", o_dma_rdt); end
         end
      end
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      m_cyc[2] = 1'b0;
      #1;
      n_cmp++; if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL at_no_err: got %b want 0", o_timeout_err); end
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL at_idle: got %0d want 0", o_grant); end
   endtask

   task automatic test_reset_mid_busy();
      set_req(1, 32'h0000_4000, 32'h0, 4'hF, 1'b1);
      @(negedge i_wb_clk);
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      i_wb_ack = 1'b0;
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd2) begin n_fail++; $display("FAIL rb_grant: got %0d want 2", o_grant); end
      reset    = 1'b1;
      i_wb_ack = 1'b1;
      #1;
      n_cmp++; if (acks !== 3'b000) begin n_fail++; $display("FAIL rb_no_ack: got %b want 000", acks); end
      @(negedge i_wb_clk);
      reset    = 1'b0;
      i_wb_ack = 1'b0;
      #1;
      n_cmp++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rb_cyc_drop: got %b want 0", o_wb_cyc); end
      n_cmp++; if (o_grant !== 2'd0) begin n_fail++; $display("FAIL rb_grant_clr: got %0d want 0", o_grant); end
      set_req(0, 32'h0000_5000, 32'h0, 4'h0, 1'b0);
      set_req(2, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
      @(negedge i_wb_clk);
      #1;
      n_cmp++; if (o_grant !== 2'd1) begin n_fail++; $display("FAIL rb_ptr_ibus: got %0d want 1", o_grant); end
      i_wb_ack = 1'b1;
      @(negedge i_wb_clk);
      idle_all();
   endtask

   // Reference model: a pending-request set per master and a pointer to the next favoured master.
   task automatic test_random();
      bit          pend [3];
      int          ptr_m, win, mode, lat, f;
      bit          err_exp, done, cyc_exp;
      logic [31:0] rd, exp_rdt;
      logic [2:0]  exp_ack;
      do_reset();
      ptr_m   = 0;
      err_exp = 1'b0;
      for (int m = 0; m < 3; m++) pend[m] = 1'b0;
      for (int t = 0; t < 150; t++) begin
         f = -1;
         if (!pend[0] && !pend[1] && !pend[2]) f = $urandom_range(2, 0);
         for (int m = 0; m < 3; m++) begin
            if (!pend[m] && (m == f || $urandom_range(1, 0) == 1)) begin
               pend[m]  = 1'b1;
               m_adr[m] = $urandom;
               m_dat[m] = $urandom;
               m_sel[m] = 4'($urandom);
               m_we[m]  = (m != 0) && ($urandom_range(1, 0) == 1);
            end
            m_cyc[m] = pend[m];
         end
         i_wb_ack  = ($urandom_range(3, 0) == 0);
         i_wb_rdt  = $urandom;
         i_err_clr = ($urandom_range(3, 0) == 0);
         #1;
         n_cmp++; if (acks !== 3'b000 || o_wb_cyc !== 1'b0 || o_grant !== 2'd0) begin
            n_fail++; $display("FAIL rnd_idle_t%0d: got ack %b cyc %b grant %0d want 000/0/0", t, acks, o_wb_cyc, o_grant);
         end
         n_cmp++; if (o_timeout_err !== err_exp) begin n_fail++; $display("FAIL rnd_err_idle_t%0d: got %b want %b", t, o_timeout_err, err_exp); end
         if (i_err_clr) err_exp = 1'b0;
         win = -1;
         for (int off = 0; off < 3; off++)
            if (win < 0 && pend[(ptr_m + off) % 3]) win = (ptr_m + off) % 3;
         mode = $urandom_range(9, 0);
         lat  = $urandom_range(TIMEOUT, 0);
         for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge i_wb_clk);
            i_wb_ack  = 1'b0;
            i_err_clr = 1'b0;
            i_wb_rdt  = $urandom;
            rd        = i_wb_rdt;
            done      = 1'b0;
            cyc_exp   = 1'b1;
            exp_ack   = 3'b000;
            exp_rdt   = rd;
            if (mode < 6 && k == lat) begin
               i_wb_ack = 1'b1;
               exp_ack  = 3'b001 << win;
               done     = 1'b1;
            end else if (mode >= 8 && k == lat) begin
               m_cyc[win] = 1'b0;
               cyc_exp    = 1'b0;
               done       = 1'b1;
            end else if (mode >= 6 && mode < 8 && k == TIMEOUT) begin
               exp_ack = 3'b001 << win;
               exp_rdt = 32'h0;
               done    = 1'b1;
            end
            #1;
            if (k == 0) begin
               n_cmp++; if (o_grant !== 2'(win + 1)) begin n_fail++; $display("FAIL rnd_grant_t%0d: got %0d want %0d", t, o_grant, win + 1); end
               n_cmp++; if (o_wb_adr !== m_adr[win] || o_wb_we !== (win != 0 && m_we[win]) ||
                            o_wb_sel !== (win == 0 ? 4'hF : m_sel[win]) || o_wb_dat !== (win == 0 ? 32'h0 : m_dat[win])) begin
                  n_fail++; $display("FAIL rnd_fields_t%0d: got %h/%h/%h/%b for master %0d", t, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, win);
               end
               n_cmp++; if (o_timeout_err !== err_exp) begin n_fail++; $display("FAIL rnd_err_busy_t%0d: got %b want %b", t, o_timeout_err, err_exp); end
            end
            n_cmp++; if (o_wb_cyc !== cyc_exp) begin n_fail++; $display("FAIL rnd_cyc_t%0d_k%0d: got %b want %b", t, k, o_wb_cyc, cyc_exp); end
            n_cmp++; if (acks !== exp_ack) begin n_fail++; $display("FAIL rnd_ack_t%0d_k%0d: got %b want %b", t, k, acks, exp_ack); end
            n_cmp++; if (rdt_of(win) !== exp_rdt) begin n_fail++; $display("FAIL rnd_rdt_t%0d_k%0d: got %h want %h", t, k, rdt_of(win), exp_rdt); end
            if (mode >= 6 && mode < 8 && k == TIMEOUT) err_exp = 1'b1;
            if (done) break;
         end
         @(negedge i_wb_clk);
         i_wb_ack   = 1'b0;
         pend[win]  = 1'b0;
         m_cyc[win] = 1'b0;
         ptr_m      = (win + 1) % 3;
      end
      idle_all();
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      test_reset();
      test_simultaneous();
      test_write();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_busy();
      test_round_robin();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
